// File: rtl/rv32_fetch_pkg.sv
// Shared types and defaults for the RV32 fetch controller.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_e;

  localparam int unsigned XLEN_DEF      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready buffer between fetch and decode, with a flush input.
module fetch_buf
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic [31:0]     load_instr_i,
  input  logic            ready_i,
  output logic            free_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = load_pc_i;
      instr_d = load_instr_i;
    end
    // Flush wins so a redirect never lets a stale instruction reach decode.
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// RV32 fetch sequencer: PC hold/select, single-outstanding imem handshake, decode buffer.
// Optional FETCH_CTRL_PERF_EN adds stall and redirect performance counters.
module fetch_ctrl
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
`ifdef FETCH_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  cur_pc_i,
  input  logic             redirect_valid_i,
  input  logic             hazard_stall_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             pc_stall_o,
  output logic             pc_sel_o,
  output logic             if_valid_o,
  output logic [XLEN-1:0]  if_pc_o,
  input  logic             if_ready_i,
`ifdef FETCH_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_redirect_cnt_o,
`endif
  output logic [31:0]      if_instr_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            fetch_req;
  logic            redirect_acc;
  logic            buf_load;
  logic            buf_free;

  // IDLE is the post-reset settle cycle; redirects there are not taken.
  assign redirect_acc = redirect_valid_i && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    fetch_req  = 1'b0;
    buf_load   = 1'b0;
    pc_stall_o = 1'b1;
    pc_sel_o   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        fetch_req = ~hazard_stall_i & ~redirect_valid_i & buf_free;
        if (fetch_req && imem_gnt_i) begin
          req_pc_d   = cur_pc_i;
          pc_stall_o = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_acc) begin
          state_d = imem_rvalid_i ? FETCH : DRAIN;
        end else if (imem_rvalid_i) begin
          buf_load = 1'b1;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        // A response arriving alongside a redirect still retires the outstanding fetch.
        if (imem_rvalid_i) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_acc) begin
      pc_stall_o = 1'b0;
      pc_sel_o   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req_o  = fetch_req;
  assign imem_addr_o = cur_pc_i;

  fetch_buf #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_fetch_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_acc),
    .load_i       (buf_load),
    .load_pc_i    (req_pc_q),
    .load_instr_i (imem_rdata_i),
    .ready_i      (if_ready_i),
    .free_o       (buf_free),
    .valid_o      (if_valid_o),
    .pc_o         (if_pc_o),
    .instr_o      (if_instr_o)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if ((state_q != IDLE) && pc_stall_o) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect_acc) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt_o    = stall_cnt_q;
  assign perf_redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC model, imem model and a delivery scoreboard.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cur_pc;
  logic        redirect, hazard, if_ready;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        pc_stall, pc_sel, if_valid;
  logic [31:0] if_pc, if_instr;

  logic        gnt_en, rv_en, in_idle;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] redirect_pc;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t sb_e;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_redir;
  int unsigned stall_model = 0;
`endif

  fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cur_pc_i         (cur_pc),
    .redirect_valid_i (redirect),
    .hazard_stall_i   (hazard),
    .imem_req_o       (req),
    .imem_addr_o      (addr),
    .imem_gnt_i       (gnt),
    .imem_rvalid_i    (rvalid),
    .imem_rdata_i     (rdata),
    .pc_stall_o       (pc_stall),
    .pc_sel_o         (pc_sel),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_ready_i       (if_ready),
`ifdef FETCH_CTRL_PERF_EN
    .perf_stall_cnt_o    (perf_stall),
    .perf_redirect_cnt_o (perf_redir),
`endif
    .if_instr_o       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // PC block model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_pc <= '0;
    else if (!pc_stall) cur_pc <= pc_sel ? redirect_pc : cur_pc + 32'd4;
  end

  // Instruction memory: response one cycle after grant, survives DUT reset
  assign gnt    = gnt_en;
  assign rvalid = pend & rv_en;
  assign rdata  = instr_of(paddr);
  always @(posedge clk) begin
    if (req && gnt) begin
      pend  <= 1'b1;
      paddr <= addr;
    end else if (rvalid) begin
      pend <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    sb_q.push_back(e);
  endtask

  // Scoreboard: every decode transfer must match the next expected instruction
  always @(negedge clk) begin
    #2;
    if (rst_n && if_valid && if_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_pc", if_pc, sb_e.pc);
        check("sb_instr", if_instr, sb_e.instr);
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always @(negedge clk) begin
    #3;
    if (!rst_n) stall_model = 0;
    else if (!in_idle && pc_stall) stall_model++;
  end
`endif

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(req), 32'd0);
    check({tag, "_addr"}, addr, cur_pc);
    check({tag, "_pc_stall"}, 32'(pc_stall), 32'd1);
    check({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_instr"}, if_instr, NOP);
  endtask

  // Ends one negedge after the IDLE cycle, with the first request to 0x0 on the bus.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; hazard = 1'b0; redirect = 1'b0; if_ready = 1'b1;
    gnt_en = 1'b1; rv_en = 1'b1; redirect_pc = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1; in_idle = 1'b1;
    #1 check("idle_req", 32'(req), 32'd0);
    @(negedge clk);
    in_idle = 1'b0;
    #1 check("first_req", 32'(req), 32'd1);
    check("first_addr", addr, 32'h0);
  endtask

  // From FETCH with a request pending and no grant: grant it, redirect in WAIT, drain.
  task automatic redirect_wait(input logic [31:0] tgt);
    rv_en = 1'b0; gnt_en = 1'b1;
    @(negedge clk);
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = tgt;
    #1 check("rw_pc_sel", 32'(pc_sel), 32'd1);
    check("rw_pc_stall", 32'(pc_stall), 32'd0);
    check("rw_req", 32'(req), 32'd0);
    @(negedge clk);
    redirect = 1'b0; rv_en = 1'b1;
    #1 check("rw_sel_pulse", 32'(pc_sel), 32'd0);
    check("rw_drain_req", 32'(req), 32'd0);
    check("rw_drop", 32'(if_valid), 32'd0);
    @(negedge clk);
    #1 check("rw_valid", 32'(if_valid), 32'd0);
    check("rw_req_tgt", 32'(req), 32'd1);
    check("rw_addr_tgt", addr, tgt);
  endtask

  task automatic finish_one(input string tag);
    @(negedge clk);
    gnt_en = 1'b0;
    @(negedge clk);
    #1 check({tag, "_valid"}, 32'(if_valid), 32'd1);
    @(negedge clk);
    #1 check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    hazard = 1'b0; redirect = 1'b0; if_ready = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
    redirect_pc = '0; in_idle = 1'b0;

    // 1: streaming, one instruction every two cycles
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8);
    @(negedge clk);
    #1 check("s1_wait_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("s1_valid", 32'(if_valid), 32'd1);
      if (i < 2) check("s1_addr", addr, 32'(4 * (i + 1)));
      @(negedge clk);
      #1 check("s1_gap", 32'(if_valid), 32'd0);
      if (i == 1) gnt_en = 1'b0;
    end
    check("s1_req_c", 32'(req), 32'd1);
    check("s1_addr_c", addr, 32'hC);
    check("s1_nogrant_stall", 32'(pc_stall), 32'd1);
    check("s1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: redirect while waiting for 0x8
    reset_dut();
    push(32'h0); push(32'h4);
    repeat (3) @(negedge clk);
    gnt_en = 1'b0;
    @(negedge clk);
    #1 check("s2_req8", addr, 32'h8);
    redirect_wait(32'h100);
    push(32'h100); gnt_en = 1'b1;
    finish_one("s2");

    // 3: hazard stall for four cycles while waiting for 0x4
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8);
    repeat (3) @(negedge clk);
    hazard = 1'b1;
    #1 check("s3_stall", 32'(pc_stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("s3_no_req", 32'(req), 32'd0);
      check("s3_pc_stall", 32'(pc_stall), 32'd1);
      if (i == 0) check("s3_deliver4", if_pc, 32'h4);
    end
    @(negedge clk);
    hazard = 1'b0;
    #1 check("s3_resume_req", 32'(req), 32'd1);
    check("s3_resume_addr", addr, 32'h8);
    finish_one("s3");

    // 4: decode back-pressure on 0xC
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    repeat (8) @(negedge clk);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("s4_hold_valid", 32'(if_valid), 32'd1);
      check("s4_hold_pc", if_pc, 32'hC);
      check("s4_hold_instr", if_instr, instr_of(32'hC));
      check("s4_no_req", 32'(req), 32'd0);
      check("s4_pc_stall", 32'(pc_stall), 32'd1);
      @(negedge clk);
    end
    if_ready = 1'b1;
    #1 check("s4_req10", 32'(req), 32'd1);
    check("s4_addr10", addr, 32'h10);
    finish_one("s4");

    // 5a: redirect coinciding with the response in WAIT
    reset_dut();
    push(32'h0); push(32'h4);
    repeat (5) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    #1 check("s5_rvalid_seen", 32'(rvalid), 32'd1);
    check("s5_pc_sel", 32'(pc_sel), 32'd1);
    @(negedge clk);
    redirect = 1'b0;
    #1 check("s5_dropped", 32'(if_valid), 32'd0);
    check("s5_req", 32'(req), 32'd1);
    check("s5_addr", addr, 32'h200);
    push(32'h200);
    finish_one("s5a");

    // 5b: reset mid-WAIT, late response lands in IDLE
    gnt_en = 1'b1;
    @(negedge clk);
    rv_en = 1'b0; rst_n = 1'b0;
    #1 check_reset_outputs("s5b_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rv_en = 1'b1; in_idle = 1'b1;
    #1 check("s5b_late_rvalid", 32'(rvalid), 32'd1);
    check("s5b_idle_req", 32'(req), 32'd0);
    @(negedge clk);
    in_idle = 1'b0;
    #1 check("s5b_ignored", 32'(if_valid), 32'd0);
    check("s5b_req", 32'(req), 32'd1);
    check("s5b_addr", addr, 32'h0);
    push(32'h0);
    finish_one("s5b");

`ifdef FETCH_CTRL_PERF_EN
    // 6: counters across two redirects
    reset_dut();
    gnt_en = 1'b0;
    @(negedge clk);
    redirect_wait(32'h100);
    redirect_wait(32'h200);
    @(negedge clk);
    #1 check("s6_redir_cnt", perf_redir, 32'd2);
    check("s6_stall_cnt", perf_stall, stall_model);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
